// File: rtl/motors_pkg.sv
// Shared types and defaults for the motion-command sequencer.
// Included first; other files import motors_pkg::*.
package motors_pkg;

  localparam int DEF_NUM_AXES            = 2;
  localparam int DEF_PULSE_NUM_WIDTH     = 16;
  localparam int DEF_STEPPER_PULSE_WIDTH = 50;

  typedef enum logic [2:0] {
    IDLE,
    SERVO_WAIT_RDY,
    SERVO_RUN,
    SETTLE,
    STEP_WAIT_RDY,
    STEP_RUN,
    DONE
  } motors_seq_state_t;

  typedef enum logic {
    PH_IDLE,
    PH_RUN
  } motors_phase_state_t;

  typedef logic signed [DEF_NUM_AXES-1:0][DEF_PULSE_NUM_WIDTH-1:0] pulse_vec_t;

endpackage

// File: rtl/motors_seq_phase.sv
// One sub-controller phase: wait for ready, strobe once, wait for done.
// fire/fin are combinational so the parent FSM can follow in the same edge.
module motors_seq_phase
  import motors_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic sub_rdy,
  input  logic sub_done,
  output logic strobe,
  output logic fire,
  output logic fin
);

  motors_phase_state_t ps;

  assign fire = req & sub_rdy & (ps == PH_IDLE);
  assign fin  = sub_done & (ps == PH_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps     <= PH_IDLE;
      strobe <= 1'b0;
    end else begin
      strobe <= fire;
      unique case (ps)
        PH_IDLE: if (fire) ps <= PH_RUN;
        PH_RUN:  if (sub_done) ps <= PH_IDLE;
        default: ps <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/motors_seq_ctrl.sv
// Pen (servo) then settle then stepper group, one done per command.
// Phases with no effective motion are skipped.
module motors_seq_ctrl
  import motors_pkg::*;
#(
  parameter int NUM_AXES            = DEF_NUM_AXES,
  parameter int PULSE_NUM_WIDTH     = DEF_PULSE_NUM_WIDTH,
  parameter int SERVO_POS_WIDTH     = 8,
  parameter int PULSE_WIDTH_WIDTH   = 16,
  parameter int STEPPER_PULSE_WIDTH = DEF_STEPPER_PULSE_WIDTH,
  parameter int SETTLE_CYCLES       = 1000,
  parameter int SERVO_POS_RESET     = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                trigger,
  input  logic [SERVO_POS_WIDTH-1:0]          servo_pos,
  input  logic [NUM_AXES*PULSE_NUM_WIDTH-1:0] pulse_num,
  output logic                                rdy,
  output logic                                done,
  output logic                                servo_trigger,
  output logic [SERVO_POS_WIDTH-1:0]          servo_pos_out,
  input  logic                                servo_rdy,
  input  logic                                servo_done,
  output logic                                steppers_trigger,
  output logic [NUM_AXES*PULSE_NUM_WIDTH-1:0] steppers_pulse_num,
  output logic [PULSE_WIDTH_WIDTH-1:0]        steppers_pulse_width,
  input  logic                                steppers_rdy,
  input  logic                                steppers_done
);

  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;
  localparam logic [SERVO_POS_WIDTH-1:0] POS_RST =
    SERVO_POS_WIDTH'(SERVO_POS_RESET);

  motors_seq_state_t          state;
  logic [SERVO_POS_WIDTH-1:0] last_pos;
  logic                       step_skip;
  logic [CW-1:0]              settle_cnt;

  logic accept;
  logic servo_skip_in;
  logic step_skip_in;
  logic servo_req;
  logic servo_fire;
  logic servo_fin;
  logic step_req;
  logic step_fire;
  logic step_fin;

  assign rdy           = (state == IDLE);
  assign accept        = rdy & trigger;
  assign servo_skip_in = (servo_pos == last_pos);
  assign step_skip_in  = (pulse_num == '0);

  // IDLE fast path lets a ready sub-controller strobe one cycle after trigger
  assign servo_req = (accept & ~servo_skip_in)
                   | (state == SERVO_WAIT_RDY);
  assign step_req  = (accept & servo_skip_in & ~step_skip_in)
                   | (state == STEP_WAIT_RDY);

  assign steppers_pulse_width = PULSE_WIDTH_WIDTH'(STEPPER_PULSE_WIDTH);

  motors_seq_phase u_servo (
    .clk      (clk),
    .reset    (reset),
    .req      (servo_req),
    .sub_rdy  (servo_rdy),
    .sub_done (servo_done),
    .strobe   (servo_trigger),
    .fire     (servo_fire),
    .fin      (servo_fin)
  );

  motors_seq_phase u_step (
    .clk      (clk),
    .reset    (reset),
    .req      (step_req),
    .sub_rdy  (steppers_rdy),
    .sub_done (steppers_done),
    .strobe   (steppers_trigger),
    .fire     (step_fire),
    .fin      (step_fin)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      last_pos           <= POS_RST;
      step_skip          <= 1'b0;
      settle_cnt         <= '0;
      done               <= 1'b0;
      servo_pos_out      <= POS_RST;
      steppers_pulse_num <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trigger) begin
            servo_pos_out      <= servo_pos;
            steppers_pulse_num <= pulse_num;
            step_skip          <= step_skip_in;
            if (!servo_skip_in) begin
              state <= servo_fire ? SERVO_RUN : SERVO_WAIT_RDY;
            end else if (!step_skip_in) begin
              state <= step_fire ? STEP_RUN : STEP_WAIT_RDY;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        SERVO_WAIT_RDY: if (servo_fire) state <= SERVO_RUN;
        SERVO_RUN: begin
          if (servo_fin) begin
            last_pos <= servo_pos_out;
            if (SETTLE_CYCLES > 0) begin
              settle_cnt <= SETTLE_LOAD;
              state      <= SETTLE;
            end else if (step_skip) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= STEP_WAIT_RDY;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            if (step_skip) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= STEP_WAIT_RDY;
            end
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        STEP_WAIT_RDY: if (step_fire) state <= STEP_RUN;
        STEP_RUN: begin
          if (step_fin) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motors_seq_ctrl.sv
// Directed bench for motors_seq_ctrl with SETTLE_CYCLES=4.
// Sub-controllers are modelled by hand-driven rdy/done levels.
module tb_motors_seq_ctrl;

  localparam int NA  = 2;
  localparam int PNW = 16;
  localparam int SPW = 8;
  localparam int PWW = 16;
  localparam int SC  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              trigger = 1'b0;
  logic [SPW-1:0]    servo_pos = '0;
  logic [NA*PNW-1:0] pulse_num = '0;
  logic              rdy;
  logic              done;
  logic              servo_trigger;
  logic [SPW-1:0]    servo_pos_out;
  logic              servo_rdy = 1'b1;
  logic              servo_done = 1'b0;
  logic              steppers_trigger;
  logic [NA*PNW-1:0] steppers_pulse_num;
  logic [PWW-1:0]    steppers_pulse_width;
  logic              steppers_rdy = 1'b1;
  logic              steppers_done = 1'b0;

  int checks = 0;
  int failures = 0;
  int n_st = 0;
  int n_pt = 0;
  int n_dn = 0;
  int st0, pt0, d0, k;

  motors_seq_ctrl #(
    .NUM_AXES            (NA),
    .PULSE_NUM_WIDTH     (PNW),
    .SERVO_POS_WIDTH     (SPW),
    .PULSE_WIDTH_WIDTH   (PWW),
    .STEPPER_PULSE_WIDTH (50),
    .SETTLE_CYCLES       (SC),
    .SERVO_POS_RESET     (0)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .trigger              (trigger),
    .servo_pos            (servo_pos),
    .pulse_num            (pulse_num),
    .rdy                  (rdy),
    .done                 (done),
    .servo_trigger        (servo_trigger),
    .servo_pos_out        (servo_pos_out),
    .servo_rdy            (servo_rdy),
    .servo_done           (servo_done),
    .steppers_trigger     (steppers_trigger),
    .steppers_pulse_num   (steppers_pulse_num),
    .steppers_pulse_width (steppers_pulse_width),
    .steppers_rdy         (steppers_rdy),
    .steppers_done        (steppers_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (servo_trigger)    n_st++;
    if (steppers_trigger) n_pt++;
    if (done)             n_dn++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_step(output int n);
    for (n = 1; n <= 20; n++) begin
      tick();
      if (steppers_trigger) break;
    end
  endtask

  task automatic wait_done(output int n);
    for (n = 1; n <= 20; n++) begin
      tick();
      if (done) break;
    end
  endtask

  task automatic cmd(input logic [SPW-1:0] p, input logic [NA*PNW-1:0] n);
    servo_pos = p;
    pulse_num = n;
    trigger   = 1'b1;
    tick();
    trigger   = 1'b0;
  endtask

  task automatic pulse_servo_done();
    servo_done = 1'b1;
    tick();
    servo_done = 1'b0;
  endtask

  task automatic pulse_step_done();
    steppers_done = 1'b1;
    tick();
    steppers_done = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_rdy", rdy, 1);
    chk("rst_done", done, 0);
    chk("rst_strobe_s", servo_trigger, 0);
    chk("rst_strobe_p", steppers_trigger, 0);
    chk("rst_pos", servo_pos_out, 0);
    chk("rst_pulses", steppers_pulse_num, 0);
    chk("pulse_width", steppers_pulse_width, 50);
    reset = 1'b1;
    tick();

    // full command: servo, settle, steppers
    d0 = n_dn;
    cmd(8'd5, {16'hffec, 16'h0064});
    chk("c1_strobe_s", servo_trigger, 1);
    chk("c1_pos", servo_pos_out, 5);
    chk("c1_pulses", steppers_pulse_num, {16'hffec, 16'h0064});
    chk("c1_busy", rdy, 0);
    servo_pos = '0;
    pulse_num = '0;
    tick();
    chk("c1_strobe_len", servo_trigger, 0);
    repeat (3) tick();
    pulse_servo_done();
    wait_step(k);
    chk("c1_settle_gap", k, SC + 1);
    chk("c1_pulses_held", steppers_pulse_num, {16'hffec, 16'h0064});
    tick();
    pulse_step_done();
    chk("c1_done", done, 1);
    tick();
    chk("c1_done_len", done, 0);
    chk("c1_rdy", rdy, 1);
    chk("c1_done_cnt", n_dn - d0, 1);

    // same servo position: stepper strobe right away
    d0 = n_dn; st0 = n_st; pt0 = n_pt;
    cmd(8'd5, {16'h0000, 16'h0003});
    chk("c2_no_servo", servo_trigger, 0);
    chk("c2_strobe_p", steppers_trigger, 1);
    chk("c2_pulses", steppers_pulse_num, {16'h0000, 16'h0003});
    tick();
    pulse_step_done();
    chk("c2_done", done, 1);
    tick();
    chk("c2_rdy", rdy, 1);

    // both phases skipped
    cmd(8'd5, '0);
    chk("c3_done", done, 1);
    chk("c3_busy", rdy, 0);
    tick();
    chk("c3_rdy", rdy, 1);
    chk("c3_done_len", done, 0);
    chk("c23_servo_cnt", n_st - st0, 0);
    chk("c23_step_cnt", n_pt - pt0, 1);
    chk("c23_done_cnt", n_dn - d0, 2);

    // servo not ready, extra trigger ignored
    d0 = n_dn; st0 = n_st;
    servo_rdy = 1'b0;
    cmd(8'd9, {16'h0001, 16'h0001});
    chk("c4_held", servo_trigger, 0);
    chk("c4_busy", rdy, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        trigger   = 1'b1;
        servo_pos = 8'd33;
      end else begin
        trigger = 1'b0;
      end
      tick();
    end
    trigger = 1'b0;
    chk("c4_wait_cnt", n_st - st0, 0);
    servo_rdy = 1'b1;
    tick();
    chk("c4_strobe_s", servo_trigger, 1);
    chk("c4_pos", servo_pos_out, 9);
    tick();
    pulse_servo_done();
    wait_step(k);
    chk("c4_settle_gap", k, SC + 1);
    tick();
    pulse_step_done();
    chk("c4_done", done, 1);
    repeat (3) tick();
    chk("c4_done_cnt", n_dn - d0, 1);
    chk("c4_servo_cnt", n_st - st0, 1);
    chk("c4_rdy", rdy, 1);

    // spurious steppers_done in IDLE and SERVO_RUN
    d0 = n_dn; pt0 = n_pt;
    pulse_step_done();
    chk("c5_idle_done", done, 0);
    chk("c5_idle_rdy", rdy, 1);
    cmd(8'd20, '0);
    chk("c5_strobe_s", servo_trigger, 1);
    tick();
    pulse_step_done();
    chk("c5_run_done", done, 0);
    chk("c5_run_busy", rdy, 0);
    pulse_servo_done();
    chk("c5_settling", done, 0);
    wait_done(k);
    chk("c5_settle_done", k, SC);
    tick();
    chk("c5_rdy", rdy, 1);
    chk("c5_done_cnt", n_dn - d0, 1);
    chk("c5_step_cnt", n_pt - pt0, 0);

    // reset during STEP_RUN
    cmd(8'd7, {16'h0005, 16'h0005});
    chk("c6_strobe_s", servo_trigger, 1);
    tick();
    pulse_servo_done();
    wait_step(k);
    chk("c6_settle_gap", k, SC + 1);
    tick();
    reset = 1'b0;
    #1;
    chk("c6_rst_rdy", rdy, 1);
    chk("c6_rst_pos", servo_pos_out, 0);
    chk("c6_rst_pulses", steppers_pulse_num, 0);
    tick();
    reset = 1'b1;
    tick();
    d0 = n_dn;
    cmd(8'd0, {16'h0000, 16'h0002});
    chk("c6_no_servo", servo_trigger, 0);
    chk("c6_strobe_p", steppers_trigger, 1);
    tick();
    pulse_step_done();
    chk("c6_done", done, 1);
    tick();
    chk("c6_rdy", rdy, 1);
    chk("c6_done_cnt", n_dn - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
